// File: rtl/axis_lane_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : axis_lane_accumulator
// Purpose  : Per-lane packet summation of an AXI-Stream; one result beat per packet.
// Revision : 1.0 - initial release
// ============================================================================
module axis_lane_accumulator #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_ADDER_BIT_WIDTH  = 32,
    parameter int C_BEAT_CNT_WIDTH   = 16
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                              s_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tuser,
    output logic [C_BEAT_CNT_WIDTH-1:0]       pkt_beats,
    output logic [31:0]                       pkt_count
);

    localparam int LP_NUM_LANES  = C_AXIS_TDATA_WIDTH / C_ADDER_BIT_WIDTH;
    localparam int LP_LANE_BYTES = C_ADDER_BIT_WIDTH / 8;
    localparam int LP_KEEP_W     = C_AXIS_TDATA_WIDTH / 8;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic                            ready_q;
    logic [C_AXIS_TDATA_WIDTH-1:0]   acc_q, acc_d;
    logic                            ovf_q, ovf_d;
    logic [C_BEAT_CNT_WIDTH-1:0]     beats_q, beats_d;
    logic [C_AXIS_TDATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                            tuser_q, tuser_d;
    logic [C_BEAT_CNT_WIDTH-1:0]     pkt_beats_q, pkt_beats_d;
    logic [31:0]                     pkt_count_q, pkt_count_d;

    logic [C_AXIS_TDATA_WIDTH-1:0]   lane_sum;
    logic [LP_NUM_LANES-1:0]         lane_carry;
    logic [C_BEAT_CNT_WIDTH-1:0]     beats_inc;
    logic                            accept;
    logic                            handoff;

    // A lane contributes only when every byte of it is kept.
    for (genvar i = 0; i < LP_NUM_LANES; i++) begin : g_lane
        logic                          keep_full;
        logic [C_ADDER_BIT_WIDTH-1:0]  addend;
        logic [C_ADDER_BIT_WIDTH:0]    sum;
        assign keep_full = &s_axis_tkeep[i*LP_LANE_BYTES +: LP_LANE_BYTES];
        assign addend    = keep_full ? s_axis_tdata[i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH]
                                     : '0;
        assign sum       = {1'b0, acc_q[i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH]} + {1'b0, addend};
        assign lane_sum[i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH] = sum[C_ADDER_BIT_WIDTH-1:0];
        assign lane_carry[i] = sum[C_ADDER_BIT_WIDTH];
    end

    // ready_q keeps the slave side closed until the first edge after reset.
    assign s_axis_tready = ready_q && (state_q == ST_ACCUM);
    assign m_axis_tvalid = (state_q == ST_EMIT);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign handoff       = m_axis_tvalid && m_axis_tready;
    assign beats_inc     = (&beats_q) ? beats_q : beats_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        beats_d     = beats_q;
        tdata_d     = tdata_q;
        tuser_d     = tuser_q;
        pkt_beats_d = pkt_beats_q;
        pkt_count_d = pkt_count_q;
        if (accept) begin
            if (s_axis_tlast) begin
                tdata_d     = lane_sum;
                tuser_d     = ovf_q | (|lane_carry);
                pkt_beats_d = beats_inc;
                acc_d       = '0;
                ovf_d       = 1'b0;
                beats_d     = '0;
                state_d     = ST_EMIT;
            end else begin
                acc_d   = lane_sum;
                ovf_d   = ovf_q | (|lane_carry);
                beats_d = beats_inc;
            end
        end
        if (handoff) begin
            state_d     = ST_ACCUM;
            pkt_count_d = pkt_count_q + 32'd1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_ACCUM;
            ready_q     <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            beats_q     <= '0;
            tdata_q     <= '0;
            tuser_q     <= 1'b0;
            pkt_beats_q <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= 1'b1;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            beats_q     <= beats_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            pkt_beats_q <= pkt_beats_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign m_axis_tdata = tdata_q;
    assign m_axis_tuser = tuser_q;
    assign m_axis_tkeep = {LP_KEEP_W{m_axis_tvalid}};
    assign m_axis_tlast = m_axis_tvalid;
    assign pkt_beats    = pkt_beats_q;
    assign pkt_count    = pkt_count_q;

endmodule
`default_nettype wire

// File: doc/axis_lane_accumulator.md
AXIS_LANE_ACCUMULATOR -- requirements
Module: axis_lane_accumulator

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 512, meaning data width of both input and output streams.
REQ-002 SHALL have parameter C_ADDER_BIT_WIDTH, default 32, meaning lane width; LP_NUM_LANES = C_AXIS_TDATA_WIDTH/C_ADDER_BIT_WIDTH.
REQ-003 SHALL have parameter C_BEAT_CNT_WIDTH, default 16, meaning width of the per-packet beat counter.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 aclk  input  1  sole clock; all state changes on its rising edge.
REQ-006 areset  input  1  asynchronous active-high reset.
REQ-007 s_axis_tvalid  input  1  upstream beat valid (fed by the adder stage output FIFO).
REQ-008 s_axis_tready  output  1  accumulator ready for a beat.
REQ-009 s_axis_tdata  input  C_AXIS_TDATA_WIDTH  LP_NUM_LANES unsigned lanes; lane i is bits [i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH].
REQ-010 s_axis_tkeep  input  C_AXIS_TDATA_WIDTH/8  byte enables.
REQ-011 s_axis_tlast  input  1  last beat of packet.
REQ-012 m_axis_tvalid  output  1  result beat valid.
REQ-013 m_axis_tready  input  1  downstream ready.
REQ-014 m_axis_tdata  output  C_AXIS_TDATA_WIDTH  per-lane packet sums, same lane layout as input.
REQ-015 m_axis_tkeep  output  C_AXIS_TDATA_WIDTH/8  all ones whenever m_axis_tvalid=1.
REQ-016 m_axis_tlast  output  1  constant 1 whenever m_axis_tvalid=1.
REQ-017 m_axis_tuser  output  1  sticky lane-overflow flag for the packet.
REQ-018 pkt_beats  output  C_BEAT_CNT_WIDTH  beats in the packet of the current result beat.
REQ-019 pkt_count  output  32  completed result beats handed off since reset.

Function
REQ-020 SHALL implement a two-state FSM: ACCUM (s_axis_tready=1, m_axis_tvalid=0) and EMIT (s_axis_tready=0, m_axis_tvalid=1).
REQ-021 Input acceptance SHALL be s_axis_tvalid & s_axis_tready; output handoff SHALL be m_axis_tvalid & m_axis_tready.
REQ-022 On each accepted beat, lane i SHALL add s_axis_tdata lane i to accumulator i modulo 2^C_ADDER_BIT_WIDTH only if all C_ADDER_BIT_WIDTH/8 tkeep bits of lane i are 1; partially kept or unkept lanes SHALL add 0.
REQ-023 Any lane carry-out on an accepted beat SHALL set the sticky overflow flag for the packet.
REQ-024 The beat counter SHALL increment per accepted beat and saturate at 2^C_BEAT_CNT_WIDTH-1.
REQ-025 On accepted beat with s_axis_tlast=1: the final sums (including that beat), overflow flag and beat count SHALL be registered to m_axis_tdata/m_axis_tuser/pkt_beats, FSM SHALL enter EMIT, m_axis_tvalid SHALL assert the next cycle (1-cycle latency); accumulators, flag and counter SHALL clear in the same cycle.
REQ-026 In EMIT, outputs SHALL hold stable until handoff; on handoff FSM SHALL return to ACCUM and s_axis_tready SHALL assert the next cycle.
REQ-027 pkt_count SHALL increment by 1 per handoff, wrapping from 0xFFFFFFFF to 0.
REQ-028 A single-beat packet (tlast on first beat) SHALL produce that beat's masked lanes as the result with pkt_beats=1.
REQ-029 s_axis_tvalid while in EMIT SHALL be ignored (no acceptance, no state change).
REQ-030 m_axis_tdata, m_axis_tuser and pkt_beats SHALL change only on the ACCUM-to-EMIT transition.

Reset
REQ-031 areset=1 SHALL immediately force FSM=ACCUM, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, pkt_beats=0, pkt_count=0, accumulators/flag/counter=0.
REQ-032 s_axis_tready SHALL rise the first aclk edge after areset deasserts; reset mid-packet or mid-EMIT SHALL discard the partial packet/result with no output beat.

Verification
REQ-033 3-beat packet, every lane = 1, 2, 3, tkeep all ones, tlast on beat 3, m_axis_tready=1 -> one result beat, every lane = 6, pkt_beats=3, tuser=0, pkt_count=1.
REQ-034 Lane 0 = 0xFFFFFFFF then 0x00000002 (tlast) -> lane 0 result 0x00000001, m_axis_tuser=1; next packet reports tuser=0.
REQ-035 Single beat, lane 3 tkeep=4'b0111, all lanes 5 -> lane 3 result 0, others 5, pkt_beats=1.
REQ-036 m_axis_tready=0 for 10 cycles after result with s_axis_tvalid held 1 -> s_axis_tready=0, outputs stable, no beat lost; accumulation resumes cycle after handoff.
REQ-037 areset pulsed after 2 beats of a 4-beat packet -> no result emitted; following 1-beat packet of lanes 7 yields all lanes 7, pkt_beats=1.
